// File: rtl/brush_stamp.sv
// brush_stamp: streams camera pixels through a frame-buffer read-modify-write, stamping a clamped square
// brush of ink (or erasing it) around the latest centre of mass. Address 1 cycle, write 3 cycles after a pixel.
module brush_stamp #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int PIX_W      = 8,
  parameter int RADIUS     = 1,
  parameter int NUM_COLORS = 4,
  localparam int ADDR_W    = $clog2(H_RES * V_RES),
  localparam int XW        = $clog2(H_RES),
  localparam int YW        = $clog2(V_RES),
  localparam int CW        = $clog2(NUM_COLORS)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [XW-1:0]     x_com_in,
  input  logic [YW-1:0]     y_com_in,
  input  logic              com_valid_in,
  input  logic [XW:0]       hcount_in,
  input  logic [YW:0]       vcount_in,
  input  logic              pixel_valid_in,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic [CW-1:0]     color_select,
  input  logic              write_erase_select,
  input  logic              clear_in,
  input  logic [PIX_W-1:0]  bram_rdata_in,
  output logic [ADDR_W-1:0] bram_raddr_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [PIX_W-1:0]  wr_pixel_out,
  output logic              wr_valid_out,
  output logic              armed_out
);
  localparam int XE = XW + 4;
  localparam int YE = YW + 4;
  localparam logic [XE-1:0] X_MAX = XE'(H_RES - 1);
  localparam logic [YE-1:0] Y_MAX = YE'(V_RES - 1);
  localparam logic [XE-1:0] X_RAD = XE'(RADIUS);
  localparam logic [YE-1:0] Y_RAD = YE'(RADIUS);

  typedef enum logic [1:0] {IDLE, ARMED, SWEEP} state_t;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  pix;
    logic [CW-1:0]     color;
    logic              erase;
    logic              inbox;
    logic              clr;
  } stage_t;

  state_t            state_q, state_d;
  logic              pend_vld_q, pend_vld_d;
  logic [XW-1:0]     px_q, px_d;
  logic [YW-1:0]     py_q, py_d;
  logic [XW-1:0]     bx_lo_q, bx_lo_d, bx_hi_q, bx_hi_d;
  logic [YW-1:0]     by_lo_q, by_lo_d, by_hi_q, by_hi_d;
  logic              clr_pend_q, clr_pend_d;
  logic              clr_act_q, clr_act_d;
  stage_t            s0, s1_q, s2_q, s3_q;

  logic              frame_start, com_ok, pix_ok, ink;
  logic [XE-1:0]     px_e;
  logic [YE-1:0]     py_e;
  logic [XW-1:0]     cx_lo, cx_hi;
  logic [YW-1:0]     cy_lo, cy_hi;
  logic [PIX_W-1:0]  stamp_pix;

  assign frame_start = pixel_valid_in && (hcount_in == '0) && (vcount_in == '0);
  assign com_ok      = com_valid_in && (XE'(x_com_in) <= X_MAX) && (YE'(y_com_in) <= Y_MAX);
  assign pix_ok      = pixel_valid_in && (XE'(hcount_in) <= X_MAX) && (YE'(vcount_in) <= Y_MAX);

  // Brush edges are clamped to the frame so a box near a border never wraps.
  assign px_e  = XE'(px_q);
  assign py_e  = YE'(py_q);
  assign cx_lo = (px_e < X_RAD) ? '0 : XW'(px_e - X_RAD);
  assign cx_hi = (px_e + X_RAD > X_MAX) ? XW'(X_MAX) : XW'(px_e + X_RAD);
  assign cy_lo = (py_e < Y_RAD) ? '0 : YW'(py_e - Y_RAD);
  assign cy_hi = (py_e + Y_RAD > Y_MAX) ? YW'(Y_MAX) : YW'(py_e + Y_RAD);

  // A pending centre at frame start goes straight to SWEEP (ARMED is left in the same edge),
  // so the frame right after the pending centre arrives is the one that gets stamped.
  always_comb begin
    state_d    = state_q;
    pend_vld_d = pend_vld_q;
    px_d       = px_q;
    py_d       = py_q;
    bx_lo_d    = bx_lo_q;
    bx_hi_d    = bx_hi_q;
    by_lo_d    = by_lo_q;
    by_hi_d    = by_hi_q;
    clr_pend_d = clr_pend_q;
    clr_act_d  = clr_act_q;
    if (frame_start) begin
      clr_act_d  = clr_pend_q;
      clr_pend_d = 1'b0;
      if ((state_q != IDLE) && pend_vld_q) begin
        state_d    = SWEEP;
        pend_vld_d = 1'b0;
        bx_lo_d    = cx_lo;
        bx_hi_d    = cx_hi;
        by_lo_d    = cy_lo;
        by_hi_d    = cy_hi;
      end else if (state_q == SWEEP) begin
        state_d = IDLE;
      end
    end
    if (clear_in) clr_pend_d = 1'b1;
    if (com_ok) begin
      px_d       = x_com_in;
      py_d       = y_com_in;
      pend_vld_d = 1'b1;
      if (state_d == IDLE) state_d = ARMED;
    end
  end

  // Next-state box/flags are used so the frame-start pixel already belongs to the new frame.
  always_comb begin
    s0       = '0;
    s0.vld   = pix_ok;
    s0.addr  = ADDR_W'(vcount_in) * ADDR_W'(H_RES) + ADDR_W'(hcount_in);
    s0.pix   = pixel_in;
    s0.color = color_select;
    s0.erase = write_erase_select;
    s0.clr   = clr_act_d;
    s0.inbox = (state_d == SWEEP) &&
               (XE'(hcount_in) >= XE'(bx_lo_d)) && (XE'(hcount_in) <= XE'(bx_hi_d)) &&
               (YE'(vcount_in) >= YE'(by_lo_d)) && (YE'(vcount_in) <= YE'(by_hi_d));
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      pend_vld_q <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
      bx_lo_q    <= '0;
      bx_hi_q    <= '0;
      by_lo_q    <= '0;
      by_hi_q    <= '0;
      clr_pend_q <= 1'b0;
      clr_act_q  <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      px_q       <= px_d;
      py_q       <= py_d;
      bx_lo_q    <= bx_lo_d;
      bx_hi_q    <= bx_hi_d;
      by_lo_q    <= by_lo_d;
      by_hi_q    <= by_hi_d;
      clr_pend_q <= clr_pend_d;
      clr_act_q  <= clr_act_d;
      s1_q       <= s0;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
    end
  end

  assign bram_raddr_out = s1_q.addr;
  assign wr_addr_out    = s3_q.addr;
  assign armed_out      = (state_q != IDLE);
  assign ink            = (bram_rdata_in[PIX_W-1 -: 2] == 2'b11);

  always_comb begin
    stamp_pix               = '0;
    stamp_pix[CW-1:0]       = s3_q.color;
    stamp_pix[PIX_W-1 -: 2] = 2'b11;
    wr_valid_out            = 1'b0;
    wr_pixel_out            = s3_q.pix;
    if (s3_q.vld) begin
      if (s3_q.clr) begin
        wr_valid_out = 1'b1;
      end else if (!s3_q.erase) begin
        if (!ink) begin
          wr_valid_out = 1'b1;
          if (s3_q.inbox) wr_pixel_out = stamp_pix;
        end
      end else if (!ink || s3_q.inbox) begin
        wr_valid_out = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_brush_stamp.sv
// Bench for brush_stamp: directed scenarios plus random frames, checked against a frame-level
// reference model and a 2-cycle-latency frame-buffer model.
module tb_brush_stamp;
  localparam int H  = 320;
  localparam int V  = 240;
  localparam int PW = 8;
  localparam int R  = 1;
  localparam int NC = 4;
  localparam int AW = $clog2(H * V);
  localparam int XW = $clog2(H);
  localparam int YW = $clog2(V);
  localparam int CW = $clog2(NC);

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [XW-1:0] x_com_in;
  logic [YW-1:0] y_com_in;
  logic          com_valid_in;
  logic [XW:0]   hcount_in;
  logic [YW:0]   vcount_in;
  logic          pixel_valid_in;
  logic [PW-1:0] pixel_in;
  logic [CW-1:0] color_select;
  logic          write_erase_select;
  logic          clear_in;
  logic [PW-1:0] bram_rdata_in;
  logic [AW-1:0] bram_raddr_out;
  logic [AW-1:0] wr_addr_out;
  logic [PW-1:0] wr_pixel_out;
  logic          wr_valid_out;
  logic          armed_out;

  always #5 clk_in = ~clk_in;

  brush_stamp #(.H_RES(H), .V_RES(V), .PIX_W(PW), .RADIUS(R), .NUM_COLORS(NC)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .x_com_in(x_com_in), .y_com_in(y_com_in),
    .com_valid_in(com_valid_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .pixel_valid_in(pixel_valid_in), .pixel_in(pixel_in), .color_select(color_select),
    .write_erase_select(write_erase_select), .clear_in(clear_in), .bram_rdata_in(bram_rdata_in),
    .bram_raddr_out(bram_raddr_out), .wr_addr_out(wr_addr_out), .wr_pixel_out(wr_pixel_out),
    .wr_valid_out(wr_valid_out), .armed_out(armed_out)
  );

  // Frame buffer: data appears two cycles after the address.
  logic [PW-1:0] mem [H*V];
  logic [PW-1:0] rd_p1, rd_p2;
  always @(posedge clk_in) begin
    rd_p1 <= mem[bram_raddr_out];
    rd_p2 <= rd_p1;
  end
  assign bram_rdata_in = rd_p2;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int            addr;
    logic [PW-1:0] pix;
    int            cyc;
  } exp_t;
  exp_t expq[$];

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt, ink_cnt, a0_cnt, a1605_cnt;

  bit m_pend, m_sweep, m_cpend, m_cact;
  int m_px, m_py, m_bx, m_by;
  bit cur_erase, rand_color;
  int cur_color;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_sweep = 0; m_cpend = 0; m_cact = 0;
    m_px = 0; m_py = 0; m_bx = 0; m_by = 0;
    expq.delete();
  endtask

  task automatic clr_cnt();
    wr_cnt = 0; ink_cnt = 0; a0_cnt = 0; a1605_cnt = 0;
  endtask

  // One input cycle; the reference model follows the frame-level rules.
  task automatic drive(input bit pv, input int h, input int v, input bit cv, input int cx,
                       input int cy, input bit clr);
    int addr, dx, dy, col;
    bit ink, inb, wr;
    logic [PW-1:0] pix, wp;
    @(posedge clk_in);
    #1;
    pix = PW'($urandom_range(0, 191));
    col = rand_color ? $urandom_range(0, NC - 1) : cur_color;
    pixel_valid_in     = pv;
    hcount_in          = (XW+1)'(h);
    vcount_in          = (YW+1)'(v);
    pixel_in           = pix;
    color_select       = CW'(col);
    write_erase_select = cur_erase;
    com_valid_in       = cv;
    x_com_in           = XW'(cx);
    y_com_in           = YW'(cy);
    clear_in           = clr;
    if (pv && h == 0 && v == 0) begin
      m_cact  = m_cpend;
      m_cpend = 0;
      if (m_pend) begin
        m_sweep = 1; m_bx = m_px; m_by = m_py; m_pend = 0;
      end else begin
        m_sweep = 0;
      end
    end
    if (clr) m_cpend = 1;
    if (cv && cx < H && cy < V) begin
      m_pend = 1; m_px = cx; m_py = cy;
    end
    if (pv && h < H && v < V) begin
      addr = v * H + h;
      ink  = (mem[addr][PW-1:PW-2] == 2'b11);
      dx   = (h > m_bx) ? h - m_bx : m_bx - h;
      dy   = (v > m_by) ? v - m_by : m_by - v;
      inb  = m_sweep && dx <= R && dy <= R;
      wr   = 1;
      wp   = pix;
      if (m_cact) wr = 1;
      else if (!cur_erase) begin
        if (ink) wr = 0;
        else if (inb) wp = 8'hC0 | PW'(col);
      end else if (ink && !inb) wr = 0;
      if (wr) expq.push_back('{addr, wp, cyc + 3});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Frame start pixel (optional) then a raster rectangle, then one off-frame column.
  task automatic rect(input int x0, input int x1, input int y0, input int y1, input bit start);
    if (start) drive(1, 0, 0, 0, 0, 0, 0);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        if (!(x == 0 && y == 0)) drive(1, x, y, 0, 0, 0, 0);
    drive(1, H, y0, 0, 0, 0, 0);
  endtask

  task automatic check_armed(input string tag);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_in);
    check(tag, armed_out, (m_pend || m_sweep));
  endtask

  always @(negedge clk_in) begin
    exp_t e;
    if (rst_in) begin
      vectors++;
      if (expq.size() > 0 && expq[0].cyc <= cyc) begin
        e = expq.pop_front();
        assert (wr_valid_out === 1'b1 && wr_addr_out === AW'(e.addr) &&
                wr_pixel_out === e.pix && e.cyc == cyc)
        else begin
          miscompares++;
          $error("FAIL wr_port cyc=%0d observed vld=%0b addr=%0d pix=%h expected addr=%0d pix=%h",
                 cyc, wr_valid_out, wr_addr_out, wr_pixel_out, e.addr, e.pix);
        end
      end else begin
        assert (wr_valid_out === 1'b0)
        else begin
          miscompares++;
          $error("FAIL wr_spurious cyc=%0d observed addr=%0d pix=%h expected no write",
                 cyc, wr_addr_out, wr_pixel_out);
        end
      end
      if (wr_valid_out === 1'b1) begin
        wr_cnt++;
        if (wr_pixel_out[PW-1:PW-2] == 2'b11) ink_cnt++;
        if (wr_addr_out == 0) a0_cnt++;
        if (wr_addr_out == 1605) a1605_cnt++;
      end
    end
  end

  initial begin
    int cx, cy, wx, wy;
    rst_in = 0; pixel_valid_in = 0; hcount_in = '0; vcount_in = '0; pixel_in = '0;
    com_valid_in = 0; x_com_in = '0; y_com_in = '0; color_select = '0;
    write_erase_select = 0; clear_in = 0;
    cur_erase = 0; rand_color = 0; cur_color = 2;
    for (int a = 0; a < H * V; a++) mem[a] = '0;
    model_reset();
    clr_cnt();
    #12;
    check("rst_wr_valid", wr_valid_out, 0);
    check("rst_armed", armed_out, 0);
    check("rst_raddr", bram_raddr_out, 0);
    check("rst_wr_addr", wr_addr_out, 0);
    @(posedge clk_in); #3 rst_in = 1;

    // Centre (5,5), colour 2 on a blank buffer.
    drive(0, 0, 0, 1, 5, 5, 0);
    rect(0, 9, 0, 9, 1);
    idle(4);
    check("c55_ink_writes", ink_cnt, 9);
    check("c55_all_writes", wr_cnt, 100);
    check_armed("c55_armed_sweep");
    check("c55_armed_high", armed_out, 1);

    // Corner (0,239): clamped, no wrap.
    clr_cnt();
    drive(0, 0, 0, 1, 0, 239, 0);
    rect(0, 3, 237, 239, 1);
    rect(316, 319, 237, 239, 0);
    rect(0, 3, 0, 1, 0);
    rect(316, 319, 0, 1, 0);
    idle(4);
    check("corner_ink_writes", ink_cnt, 4);

    // Erase mode around (5,5) with ink at 1605 and 0.
    clr_cnt();
    cur_erase = 1;
    mem[1605] = 8'hC1;
    mem[0]    = 8'hC3;
    drive(0, 0, 0, 1, 5, 5, 0);
    rect(0, 9, 0, 9, 1);
    idle(4);
    check("erase_addr0_writes", a0_cnt, 0);
    check("erase_1605_writes", a1605_cnt, 1);
    check("erase_ink_writes", ink_cnt, 0);
    mem[1605] = '0;
    mem[0]    = '0;
    cur_erase = 0;

    // New centre mid-sweep applies only to the following frame.
    clr_cnt();
    drive(0, 0, 0, 1, 5, 5, 0);
    rect(0, 9, 0, 9, 1);
    drive(0, 0, 0, 1, 100, 100, 0);
    rect(97, 103, 97, 103, 0);
    idle(4);
    check("frameN_ink", ink_cnt, 9);
    clr_cnt();
    rect(0, 9, 0, 9, 1);
    rect(97, 103, 97, 103, 0);
    idle(4);
    check("frameN1_ink", ink_cnt, 9);
    clr_cnt();
    rect(0, 2, 0, 2, 1);
    idle(4);
    check("frameN2_ink", ink_cnt, 0);
    check_armed("idle_armed_model");
    check("idle_armed_low", armed_out, 0);

    // Clear over a buffer full of ink, then ink is preserved again.
    for (int a = 0; a < H * V; a++) mem[a] = 8'hC0 | PW'($urandom_range(0, 63));
    clr_cnt();
    drive(0, 0, 0, 0, 0, 0, 1);
    rect(0, 9, 0, 9, 1);
    idle(4);
    check("clear_frame_writes", wr_cnt, 100);
    clr_cnt();
    rect(0, 9, 0, 9, 1);
    idle(4);
    check("post_clear_writes", wr_cnt, 0);

    // Random frames.
    for (int a = 0; a < H * V; a++)
      mem[a] = ($urandom_range(0, 3) == 0) ? (8'hC0 | PW'($urandom_range(0, 63)))
                                           : PW'($urandom_range(0, 191));
    rand_color = 1;
    for (int f = 0; f < 8; f++) begin
      cx = $urandom_range(0, H - 1);
      cy = $urandom_range(0, V - 1);
      if ($urandom_range(0, 5) == 0) cx = H + $urandom_range(0, 100);
      cur_erase = 1'($urandom_range(0, 1));
      drive(0, 0, 0, 1, cx, cy, ($urandom_range(0, 3) == 0));
      wx = (cx < H) ? cx : 5;
      wy = cy;
      rect(0, 2, 0, 2, 1);
      rect((wx > 3) ? wx - 3 : 0, (wx + 3 < H) ? wx + 3 : H - 1,
           (wy > 3) ? wy - 3 : 0, (wy + 3 < V) ? wy + 3 : V - 1, 0);
      idle(4);
      check_armed("rand_armed");
    end
    rand_color = 0;
    cur_erase  = 0;

    // Reset mid-frame with writes in flight.
    for (int a = 0; a < H * V; a++) mem[a] = '0;
    drive(0, 0, 0, 1, 50, 50, 0);
    for (int x = 0; x < 6; x++) drive(1, x, 0, 0, 0, 0, 0);
    #1;
    check("prereset_wr_valid", wr_valid_out, 1);
    #1 rst_in = 0;
    model_reset();
    pixel_valid_in = 0; com_valid_in = 0; clear_in = 0;
    #1;
    check("midrst_wr_valid", wr_valid_out, 0);
    check("midrst_wr_addr", wr_addr_out, 0);
    check("midrst_wr_pixel", wr_pixel_out, 0);
    check("midrst_raddr", bram_raddr_out, 0);
    check("midrst_armed", armed_out, 0);
    @(posedge clk_in);
    @(posedge clk_in);
    #3 rst_in = 1;
    clr_cnt();
    idle(3);
    @(negedge clk_in);
    check("postrst_writes", wr_cnt, 0);
    check("postrst_armed", armed_out, 0);

    // Normal operation resumes after reset.
    clr_cnt();
    drive(0, 0, 0, 1, 5, 5, 0);
    rect(0, 9, 0, 9, 1);
    idle(4);
    check("recover_ink", ink_cnt, 9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
